ciccio_rr_mux: RTL and testbench
================================

// Module: ciccio_rr_mux
// PURPOSE
//  Parametrised successor to the 1-bit 2:1 select mux: N-channel, W-bit, registered
//  multiplexer with valid/ready handshakes on every input and on the output.
//  Two modes: explicit select (io_sel) or round-robin arbitration among valid inputs.
//  Sits between producer channels and a single consumer; one output register stage.
// PARAMETERS
//  N     2  number of input channels (>=2)
//  W     1  data width in bits (>=1)
//  SELW  clog2(N) (localparam, min 1) width of io_sel / io_out_chan
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  io_mode      in   1       0 = SEL (explicit), 1 = RR (round-robin)
//  io_sel       in   SELW    channel index used in SEL mode
//  io_in_valid  in   N       per-channel valid
//  io_in_bits   in   N*W     channel i at bits [i*W +: W]
//  io_in_ready  out  N       per-channel ready (at most one high)
//  io_out_valid out  1       output register holds data
//  io_out_ready in   1       consumer accepts this cycle
//  io_out_bits  out  W       registered data
//  io_out_chan  out  SELW    index of the channel the data came from
// BEHAVIOUR
//  Reset (reset=1 at edge): out_valid=0, out_bits=0, out_chan=0, rr_ptr=N-1; io_in_ready=0
//   while reset is high. Reset mid-transfer discards held data; no handshake completes.
//  load = !out_valid || io_out_ready  (output reg empty or draining this cycle).
//  Grant (combinational, one-hot or zero):
//   SEL: grant[io_sel] = io_in_valid[io_sel]; io_sel >= N -> no grant, nothing accepted.
//   RR : first valid channel scanning rr_ptr+1, rr_ptr+2, ... wrapping modulo N.
//  io_in_ready[i] = load && grant[i] && !reset. Transfer on channel i = valid[i] && ready[i].
//  On transfer: out_bits <= in_bits[i], out_chan <= i, out_valid <= 1 (1-cycle latency).
//  load && no transfer: out_valid <= 0 (out_bits/out_chan hold last value).
//  out_valid && !io_out_ready: out_bits/out_chan stable, no input accepted.
//  Full throughput: one transfer per cycle while consumer holds io_out_ready=1.
//  rr_ptr <= i only on a transfer in RR mode; SEL mode transfers leave rr_ptr unchanged.
//  Wrap: rr_ptr=N-1 -> channel 0 scanned first. No valid inputs -> no grant, ptr holds.
//  Mode/sel change takes effect same cycle for grant; held output unaffected.
//  ready never depends on in_valid of other channels in SEL mode; in RR mode a channel's
//   ready depends only on valids, not on its own ready (no comb loop through out_ready
//   beyond load).
// STRUCTURE
//  ciccio_pkg: MODE_SEL=1'b0, MODE_RR=1'b1 constants; clog2 function.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr[SELW]; outputs gnt[N] one-hot, gnt_idx,
//   any. Top instantiates it, muxes SEL/RR grant, owns output register and rr_ptr.
// TESTING
//  1 N=2,W=1,SEL: sel=1, in1=1 valid, out_ready=1 -> next cycle out_valid=1, bits=1, chan=1;
//    matches legacy 2:1 mux one cycle delayed.
//  2 N=4,W=8,RR: all valid, bits=8'h10..8'h13, out_ready=1 -> chan order 0,1,2,3,0 on
//    consecutive cycles, each in_ready pulses once per 4 cycles.
//  3 RR backpressure: out_ready=0 after first transfer -> out_bits held, all in_ready=0;
//    release -> next grant is ptr+1, no data lost or duplicated.
//  4 RR sparse: only ch3 and ch1 valid, ptr=1 -> grant ch3, then ch1; ptr wraps via 0.
//  5 SEL with io_sel=5 at N=4 -> no in_ready, out_valid drops to 0 after drain.
//  6 reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, chan=0;
//    first RR grant after reset is ch0.
//  Scoreboard: every accepted (chan,bits) appears exactly once, in order, at the output.

Source files
------------

// File: rtl/ciccio_pkg.sv
// Shared constants and helpers for the round-robin / select multiplexer.
package ciccio_pkg;

    // io_mode encodings
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2, never less than 1 so index ports always have at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ciccio_rr_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter
    import ciccio_pkg::*;
#(
    parameter  int N    = 2,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    // cand_idx[k] is the channel scanned in position k: (ptr + 1 + k) mod N.
    logic [SELW-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [SELW:0] raw_sum;
            // ptr < N and gi+1 <= N, so one conditional subtraction is a full modulo.
            assign raw_sum = {1'b0, ptr} + (SELW+1)'(gi + 1);
            assign cand_idx[gi] = (raw_sum >= (SELW+1)'(N)) ?
                                  SELW'(raw_sum - (SELW+1)'(N)) : raw_sum[SELW-1:0];
        end
    endgenerate

    // Priority scan in rotated order; first valid candidate wins.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[cand_idx[k]]) begin
                any     = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = any && (gnt_idx == SELW'(gi));
        end
    endgenerate

endmodule

// File: rtl/ciccio_rr_mux.sv
// N-channel registered multiplexer with valid/ready on every port.
// Explicit-select or round-robin arbitration, one output register stage.
module ciccio_rr_mux
    import ciccio_pkg::*;
#(
    parameter  int N    = 2,
    parameter  int W    = 1,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_mode,
    input  logic [SELW-1:0] io_sel,
    input  logic [N-1:0]    io_in_valid,
    input  logic [N*W-1:0]  io_in_bits,
    output logic [N-1:0]    io_in_ready,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [W-1:0]    io_out_bits,
    output logic [SELW-1:0] io_out_chan
);

    logic            out_valid_reg, out_valid_next;
    logic [W-1:0]    out_bits_reg,  out_bits_next;
    logic [SELW-1:0] out_chan_reg,  out_chan_next;
    logic [SELW-1:0] rr_ptr_reg,    rr_ptr_next;

    logic [N-1:0]    rr_gnt, sel_gnt, grant;
    logic [SELW-1:0] rr_idx, grant_idx;
    logic            rr_any, grant_any, sel_in_range, load, xfer;
    logic [W-1:0]    in_bits_arr [N];

    rr_arbiter #(.N(N)) u_arb (
        .req     (io_in_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // An out-of-range select grants nothing.
    assign sel_in_range = ({1'b0, io_sel} < (SELW+1)'(N));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign sel_gnt[gi]     = sel_in_range && (io_sel == SELW'(gi)) && io_in_valid[gi];
            assign in_bits_arr[gi] = io_in_bits[gi*W +: W];
        end
    endgenerate

    assign grant     = (io_mode == MODE_RR) ? rr_gnt : sel_gnt;
    assign grant_idx = (io_mode == MODE_RR) ? rr_idx : io_sel;
    assign grant_any = (io_mode == MODE_RR) ? rr_any : (|sel_gnt);

    // Output register can take new data when empty or being drained this cycle.
    assign load        = !out_valid_reg || io_out_ready;
    assign io_in_ready = (load && !reset) ? grant : '0;
    assign xfer        = load && !reset && grant_any;

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_bits_next  = out_bits_reg;
        out_chan_next  = out_chan_reg;
        rr_ptr_next    = rr_ptr_reg;
        if (load) begin
            out_valid_next = xfer;
            if (xfer) begin
                out_bits_next = in_bits_arr[grant_idx];
                out_chan_next = grant_idx;
                if (io_mode == MODE_RR) begin
                    rr_ptr_next = grant_idx;
                end
            end
        end
    end

    // State registers; reset parks the pointer at N-1 so channel 0 is scanned first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_bits_reg  <= '0;
            out_chan_reg  <= '0;
            rr_ptr_reg    <= SELW'(N - 1);
        end else begin
            out_valid_reg <= out_valid_next;
            out_bits_reg  <= out_bits_next;
            out_chan_reg  <= out_chan_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign io_out_valid = out_valid_reg;
    assign io_out_bits  = out_bits_reg;
    assign io_out_chan  = out_chan_reg;

endmodule

// File: tb/tb_ciccio_rr_mux.sv
// Directed bench: N=4/W=8 vector table plus N=2/W=1 and N=3/W=4 corner sequences.
module tb_ciccio_rr_mux;
    import ciccio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: N=4, W=8 ----------------
    logic        a_rst, a_mode, a_ov, a_ordy;
    logic [1:0]  a_sel, a_chan;
    logic [3:0]  a_vld, a_rdy;
    logic [31:0] a_bits_in;
    logic [7:0]  a_bits;

    ciccio_rr_mux #(.N(4), .W(8)) dut_a (
        .clk(clk), .reset(a_rst), .io_mode(a_mode), .io_sel(a_sel),
        .io_in_valid(a_vld), .io_in_bits(a_bits_in), .io_in_ready(a_rdy),
        .io_out_valid(a_ov), .io_out_ready(a_ordy), .io_out_bits(a_bits),
        .io_out_chan(a_chan)
    );

    // ---------------- DUT B: N=2, W=1 ----------------
    logic       b_rst, b_mode, b_sel, b_ov, b_ordy, b_bits, b_chan;
    logic [1:0] b_vld, b_rdy, b_bits_in;

    ciccio_rr_mux #(.N(2), .W(1)) dut_b (
        .clk(clk), .reset(b_rst), .io_mode(b_mode), .io_sel(b_sel),
        .io_in_valid(b_vld), .io_in_bits(b_bits_in), .io_in_ready(b_rdy),
        .io_out_valid(b_ov), .io_out_ready(b_ordy), .io_out_bits(b_bits),
        .io_out_chan(b_chan)
    );

    // ---------------- DUT C: N=3, W=4 ----------------
    logic        c_rst, c_mode, c_ov, c_ordy;
    logic [1:0]  c_sel, c_chan;
    logic [2:0]  c_vld, c_rdy;
    logic [11:0] c_bits_in;
    logic [3:0]  c_bits;

    ciccio_rr_mux #(.N(3), .W(4)) dut_c (
        .clk(clk), .reset(c_rst), .io_mode(c_mode), .io_sel(c_sel),
        .io_in_valid(c_vld), .io_in_bits(c_bits_in), .io_in_ready(c_rdy),
        .io_out_valid(c_ov), .io_out_ready(c_ordy), .io_out_bits(c_bits),
        .io_out_chan(c_chan)
    );

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_bits;
        logic [1:0] exp_chan;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];
    logic [9:0] sb_q [$];   // {chan, bits} accepted but not yet consumed

    function automatic vec_t mk(input logic rst, input logic mode, input logic [1:0] sel,
                                input logic [3:0] vld, input logic ordy, input logic [3:0] er,
                                input logic eov, input logic [7:0] eb, input logic [1:0] ec);
        vec_t v;
        v.rst = rst; v.mode = mode; v.sel = sel; v.vld = vld; v.ordy = ordy;
        v.exp_rdy = er; v.exp_ov = eov; v.exp_bits = eb; v.exp_chan = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] item;
        a_rst = 1'b1; a_mode = MODE_RR; a_sel = 2'd0; a_vld = 4'h0; a_ordy = 1'b1;
        a_bits_in = {8'h13, 8'h12, 8'h11, 8'h10};
        b_rst = 1'b1; b_mode = MODE_SEL; b_sel = 1'b0; b_vld = 2'b00; b_ordy = 1'b1;
        b_bits_in = 2'b00;
        c_rst = 1'b1; c_mode = MODE_SEL; c_sel = 2'd0; c_vld = 3'b000; c_ordy = 1'b1;
        c_bits_in = {4'h7, 4'h6, 4'h5};

        //                rst   mode      sel   vld   ordy  rdy   ov    bits   chan
        vecs[0]  = mk(1'b1, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0);
        vecs[1]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);
        vecs[2]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1);
        vecs[3]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2);
        vecs[4]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3);
        vecs[5]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);
        vecs[6]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'h10, 2'd0);
        vecs[7]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'h10, 2'd0);
        vecs[8]  = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1);
        vecs[9]  = mk(1'b0, MODE_RR,  2'd0, 4'hA, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3);
        vecs[10] = mk(1'b0, MODE_RR,  2'd0, 4'hA, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1);
        vecs[11] = mk(1'b0, MODE_RR,  2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1);
        vecs[12] = mk(1'b0, MODE_RR,  2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1);
        vecs[13] = mk(1'b0, MODE_SEL, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2);
        vecs[14] = mk(1'b0, MODE_SEL, 2'd2, 4'hB, 1'b1, 4'h0, 1'b0, 8'h12, 2'd2);
        vecs[15] = mk(1'b0, MODE_SEL, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);
        vecs[16] = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2);
        vecs[17] = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'h12, 2'd2);
        vecs[18] = mk(1'b1, MODE_RR,  2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0);
        vecs[19] = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);
        vecs[20] = mk(1'b0, MODE_RR,  2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 8'h10, 2'd0);
        vecs[21] = mk(1'b0, MODE_RR,  2'd0, 4'h4, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2);
        vecs[22] = mk(1'b0, MODE_SEL, 2'd3, 4'hF, 1'b0, 4'h0, 1'b1, 8'h12, 2'd2);
        vecs[23] = mk(1'b0, MODE_SEL, 2'd3, 4'hF, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3);
        vecs[24] = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3);
        vecs[25] = mk(1'b0, MODE_RR,  2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);

        @(posedge clk); #1;

        // ---- DUT A: table-driven, with a handshake scoreboard ----
        for (int i = 0; i < NVEC; i++) begin
            a_rst = vecs[i].rst; a_mode = vecs[i].mode; a_sel = vecs[i].sel;
            a_vld = vecs[i].vld; a_ordy = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("a_vec%0d_in_ready", i), 32'(a_rdy), 32'(vecs[i].exp_rdy));
            if (a_rst) begin
                sb_q.delete();
            end else begin
                if (a_ov && a_ordy) begin
                    if (sb_q.size() == 0) begin
                        check($sformatf("a_vec%0d_sb_depth", i), 32'(0), 32'(1));
                    end else begin
                        item = sb_q.pop_front();
                        check($sformatf("a_vec%0d_sb_order", i), {22'd0, a_chan, a_bits}, {22'd0, item});
                    end
                end
                for (int ch = 0; ch < 4; ch++) begin
                    if (a_vld[ch] && a_rdy[ch]) begin
                        sb_q.push_back({2'(ch), a_bits_in[ch*8 +: 8]});
                    end
                end
            end
            @(posedge clk); #1;
            check($sformatf("a_vec%0d_out_valid", i), 32'(a_ov), 32'(vecs[i].exp_ov));
            check($sformatf("a_vec%0d_out_bits", i), 32'(a_bits), 32'(vecs[i].exp_bits));
            check($sformatf("a_vec%0d_out_chan", i), 32'(a_chan), 32'(vecs[i].exp_chan));
            $display("vec %0d rst=%0b mode=%0b sel=%0d vld=%h ordy=%0b -> rdy=%h ov=%0b bits=%h chan=%0d",
                     i, a_rst, a_mode, a_sel, a_vld, a_ordy, a_rdy, a_ov, a_bits, a_chan);
        end
        // Only the item still in the output register may remain unconsumed.
        check("a_sb_leftover", 32'(sb_q.size()), 32'(a_ov));

        // ---- DUT B: legacy 2:1 select mux, one cycle delayed ----
        b_rst = 1'b0;
        b_sel = 1'b1; b_vld = 2'b10; b_bits_in = 2'b10;
        @(negedge clk);
        check("b_sel1_in_ready", 32'(b_rdy), 32'(2'b10));
        @(posedge clk); #1;
        check("b_sel1_out_valid", 32'(b_ov), 32'(1));
        check("b_sel1_out_bits", 32'(b_bits), 32'(1));
        check("b_sel1_out_chan", 32'(b_chan), 32'(1));
        $display("b sel=1 in1=1 -> ov=%0b bits=%0b chan=%0b", b_ov, b_bits, b_chan);
        for (int s = 0; s < 2; s++) begin
            for (int bv = 0; bv < 4; bv++) begin
                b_sel = 1'(s); b_vld = 2'b11; b_bits_in = 2'(bv);
                @(negedge clk);
                check($sformatf("b_s%0d_b%0d_in_ready", s, bv), 32'(b_rdy), 32'(1 << s));
                @(posedge clk); #1;
                check($sformatf("b_s%0d_b%0d_out_bits", s, bv), 32'(b_bits), 32'((bv >> s) & 1));
                check($sformatf("b_s%0d_b%0d_out_chan", s, bv), 32'(b_chan), 32'(s));
                $display("b sel=%0d in=%0b -> bits=%0b chan=%0b", s, b_bits_in, b_bits, b_chan);
            end
        end

        // ---- DUT C: out-of-range select at N=3, then RR wrap ----
        c_rst = 1'b0;
        c_mode = MODE_SEL; c_sel = 2'd2; c_vld = 3'b111;
        @(negedge clk);
        check("c_sel2_in_ready", 32'(c_rdy), 32'(3'b100));
        @(posedge clk); #1;
        check("c_sel2_out_valid", 32'(c_ov), 32'(1));
        check("c_sel2_out_bits", 32'(c_bits), 32'(4'h7));
        $display("c sel=2 -> ov=%0b bits=%h chan=%0d", c_ov, c_bits, c_chan);
        c_sel = 2'd3;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check($sformatf("c_sel3_r%0d_in_ready", r), 32'(c_rdy), 32'(0));
            @(posedge clk); #1;
            check($sformatf("c_sel3_r%0d_out_valid", r), 32'(c_ov), 32'(0));
            check($sformatf("c_sel3_r%0d_out_bits", r), 32'(c_bits), 32'(4'h7));
            $display("c sel=3 -> rdy=%b ov=%0b bits=%h", c_rdy, c_ov, c_bits);
        end
        c_mode = MODE_RR;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check($sformatf("c_rr%0d_in_ready", r), 32'(c_rdy), 32'(1 << (r % 3)));
            @(posedge clk); #1;
            check($sformatf("c_rr%0d_out_chan", r), 32'(c_chan), 32'(r % 3));
            check($sformatf("c_rr%0d_out_bits", r), 32'(c_bits), 32'(5 + (r % 3)));
            $display("c rr -> rdy=%b ov=%0b bits=%h chan=%0d", c_rdy, c_ov, c_bits, c_chan);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
